// File: rtl/ck_slow2fast_fifo.sv
`timescale 1ns/100ps
// ck_slow2fast_fifo
// Dual-clock FIFO carrying words from the ckSlow (write) domain into the
// ckFast (read) domain. Each side owns a binary pointer with a registered
// Gray copy. Only the Gray copy crosses, through a two-flop synchronizer.
// The flags and occupancy levels are registered and conservative: the
// writer may see the FIFO as fuller than it is, and the reader may see it
// as emptier than it is. Neither side ever overruns the other.
module ck_slow2fast_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              ckSlow,
    input  logic              ckFast,
    input  logic              arstFast,
    input  logic              arstSlow,
    input  logic [DATA_W-1:0] wrData,
    input  logic              push,
    output logic              full,
    output logic [ADDR_W:0]   wrLevel,
    output logic              ovf,
    input  logic              pop,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              empty,
    output logic [ADDR_W:0]   rdLevel,
    output logic              udf
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage: written from ckSlow, read with a registered port in ckFast.
    // It is never reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write (ckSlow) domain ----------------
    logic [ADDR_W:0] wbin_reg, wbin_next;
    logic [ADDR_W:0] wgray_reg, wgray_next;
    logic [ADDR_W:0] rq1_gray_reg, rq2_gray_reg;
    logic [ADDR_W:0] rsync_bin;
    logic [ADDR_W:0] full_cmp;
    logic [ADDR_W:0] wr_level_reg, wr_level_next;
    logic            full_reg, full_next;
    logic            ovf_reg;
    logic            wr_en;

    // ---------------- read (ckFast) domain -----------------
    logic [ADDR_W:0]   rbin_reg, rbin_next;
    logic [ADDR_W:0]   rgray_reg, rgray_next;
    logic [ADDR_W:0]   wq1_gray_reg, wq2_gray_reg;
    logic [ADDR_W:0]   wsync_bin;
    logic [ADDR_W:0]   rd_level_reg, rd_level_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              empty_reg, empty_next;
    logic              udf_reg;
    logic              rd_en;

    // Gray-to-binary conversion of the synchronized pointers. Each binary
    // bit is the XOR of all Gray bits at or above its position.
    genvar gi;
    generate
        for (gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
            assign rsync_bin[gi] = ^rq2_gray_reg[ADDR_W:gi];
            assign wsync_bin[gi] = ^wq2_gray_reg[ADDR_W:gi];
        end
    endgenerate

    // Write side: accept, advance the pointer, and predict full and level
    // for the pointer value that the edge is about to register.
    always_comb begin
        wr_en         = push & ~full_reg;
        wbin_next     = wbin_reg + {{ADDR_W{1'b0}}, wr_en};
        wgray_next    = wbin_next ^ (wbin_next >> 1);
        // Full means the writer is one whole lap ahead of the reader. In
        // Gray code this means the two MSBs differ and the rest match.
        full_cmp      = {~rq2_gray_reg[ADDR_W:ADDR_W-1], rq2_gray_reg[ADDR_W-2:0]};
        full_next     = (wgray_next == full_cmp);
        wr_level_next = wbin_next - rsync_bin;
    end

    // Write-domain registers: pointers, read-pointer synchronizer, flags.
    always_ff @(posedge ckSlow or posedge arstSlow) begin
        if (arstSlow) begin
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            rq1_gray_reg <= '0;
            rq2_gray_reg <= '0;
            full_reg     <= 1'b0;
            wr_level_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wgray_reg    <= wgray_next;
            rq1_gray_reg <= rgray_reg;
            rq2_gray_reg <= rq1_gray_reg;
            full_reg     <= full_next;
            wr_level_reg <= wr_level_next;
            if (push && full_reg) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Memory write port. A dropped push never reaches the array.
    always_ff @(posedge ckSlow) begin
        if (wr_en) begin
            mem[wbin_reg[ADDR_W-1:0]] <= wrData;
        end
    end

    // Read side: accept, advance the pointer, and predict empty and level
    // for the pointer value that the edge is about to register.
    always_comb begin
        rd_en         = pop & ~empty_reg;
        rbin_next     = rbin_reg + {{ADDR_W{1'b0}}, rd_en};
        rgray_next    = rbin_next ^ (rbin_next >> 1);
        empty_next    = (rgray_next == wq2_gray_reg);
        rd_level_next = wsync_bin - rbin_next;
    end

    // Read-domain registers: pointers, write-pointer synchronizer, the
    // registered read port, and the flags.
    always_ff @(posedge ckFast or posedge arstFast) begin
        if (arstFast) begin
            rbin_reg     <= '0;
            rgray_reg    <= '0;
            wq1_gray_reg <= '0;
            wq2_gray_reg <= '0;
            empty_reg    <= 1'b1;
            rd_level_reg <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            udf_reg      <= 1'b0;
        end else begin
            rbin_reg     <= rbin_next;
            rgray_reg    <= rgray_next;
            wq1_gray_reg <= wgray_reg;
            wq2_gray_reg <= wq1_gray_reg;
            empty_reg    <= empty_next;
            rd_level_reg <= rd_level_next;
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_data_reg <= mem[rbin_reg[ADDR_W-1:0]];
            end
            if (pop && empty_reg) begin
                udf_reg <= 1'b1;
            end
        end
    end

    assign full    = full_reg;
    assign wrLevel = wr_level_reg;
    assign ovf     = ovf_reg;
    assign rdData  = rd_data_reg;
    assign rdValid = rd_valid_reg;
    assign empty   = empty_reg;
    assign rdLevel = rd_level_reg;
    assign udf     = udf_reg;

endmodule

// File: tb/tb_ck_slow2fast_fifo.sv
`timescale 1ns/100ps
// Bench for ck_slow2fast_fifo. A single process drives both domains and
// keeps the reference model. The model is a word queue with push and pop
// totals. The level and flag checks use bounds derived from the two-edge
// synchronizer delay and never look at the pointer encoding.
module tb_ck_slow2fast_fifo;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              ckSlow, ckFast, arstFast, arstSlow;
    logic [DATA_W-1:0] wrData, rdData;
    logic              push, full, ovf, pop, rdValid, empty, udf;
    logic [ADDR_W:0]   wrLevel, rdLevel;

    ck_slow2fast_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .ckSlow(ckSlow), .ckFast(ckFast), .arstFast(arstFast), .arstSlow(arstSlow),
        .wrData(wrData), .push(push), .full(full), .wrLevel(wrLevel), .ovf(ovf),
        .pop(pop), .rdData(rdData), .rdValid(rdValid), .empty(empty),
        .rdLevel(rdLevel), .udf(udf)
    );

    // 10 MHz write clock and 37 MHz read clock. The read clock is offset so
    // that no edge of one clock ever lands on an edge of the other.
    initial begin
        ckSlow = 1'b0;
        forever #50 ckSlow = ~ckSlow;
    end
    initial begin
        ckFast = 1'b0;
        #5.3;
        forever #13.5 ckFast = ~ckFast;
    end

    // Bookkeeping and model state
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_q[$];
    int          pushed_total, popped_total;
    int          s_h0, s_h1, s_h2;   // pops completed as of recent ckSlow edges
    int          f_h0, f_h1, f_h2;   // pushes completed as of recent ckFast edges
    logic [7:0]  exp_data;
    logic        exp_valid, exp_ovf, exp_udf;
    logic        slow_q, fast_q;
    // Stimulus controls
    int          push_target, pop_target, word_base;
    int unsigned wr_prob, rd_prob;
    logic        word_random, force_aa, allow_udf;
    logic [7:0]  got_data[16];
    int          got_n, aa_seen;

    // Checks that act equals req exactly. X or Z on act counts as a failure.
    function automatic void chk_eq(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Checks that act lies in the range lo..hi inclusive.
    function automatic void chk_rng(string name, logic [31:0] act, int lo, int hi);
        checks++;
        if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    task automatic slow_pos();
        if (push && !full) begin
            model_q.push_back(wrData);
            pushed_total++;
        end else if (push && full) begin
            exp_ovf = 1'b1;
        end
        s_h2 = s_h1; s_h1 = s_h0; s_h0 = popped_total;
    endtask

    task automatic slow_neg();
        int lo, hi;
        lo = pushed_total - s_h0;
        hi = pushed_total - s_h2;
        chk_rng("wr_level", wrLevel, lo, hi);
        chk_eq("ovf", ovf, exp_ovf);
        if (lo == 16) chk_eq("full_set", full, 1);
        if (hi < 16)  chk_eq("full_clear", full, 0);
        push = force_aa || (pushed_total < push_target && !full &&
                            $urandom_range(99) < wr_prob);
        if (force_aa)         wrData = 8'hAA;
        else if (word_random) wrData = 8'($urandom);
        else                  wrData = 8'(word_base + pushed_total);
    endtask

    task automatic fast_pos();
        if (pop && !empty) begin
            if (model_q.size() == 0) begin
                chk_eq("pop_with_model_empty", 32'(model_q.size()), 1);
                exp_valid = 1'b0;
            end else begin
                exp_data  = model_q.pop_front();
                exp_valid = 1'b1;
                popped_total++;
            end
        end else begin
            exp_valid = 1'b0;
            if (pop && empty) exp_udf = 1'b1;
        end
        f_h2 = f_h1; f_h1 = f_h0; f_h0 = pushed_total;
    endtask

    task automatic fast_neg();
        int lo, hi;
        lo = f_h2 - popped_total;
        hi = f_h0 - popped_total;
        chk_rng("rd_level", rdLevel, lo, hi);
        if (lo > 0)  chk_eq("empty_clear", empty, 0);
        if (hi == 0) chk_eq("empty_set", empty, 1);
        chk_eq("rd_valid", rdValid, exp_valid);
        chk_eq("rd_data", rdData, exp_data);
        chk_eq("udf", udf, exp_udf);
        if (rdValid === 1'b1) begin
            if (got_n < 16) got_data[got_n] = rdData;
            got_n++;
            if (rdData == 8'hAA) aa_seen++;
            $display("pop %0d: data=0x%02h rdLevel=%0d", popped_total, rdData, rdLevel);
        end
        pop = allow_udf || (popped_total < pop_target && !empty &&
                            $urandom_range(99) < rd_prob);
    endtask

    // Waits for the next clock transition and dispatches it.
    task automatic tick();
        @(ckSlow or ckFast);
        if (ckSlow && !slow_q)      slow_pos();
        else if (!ckSlow && slow_q) slow_neg();
        if (ckFast && !fast_q)      fast_pos();
        else if (!ckFast && fast_q) fast_neg();
        slow_q = ckSlow;
        fast_q = ckFast;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic run_until(int push_goal, int pop_goal, int max_ev, string name);
        int n;
        n = 0;
        while ((pushed_total < push_goal || popped_total < pop_goal) && n < max_ev) begin
            tick();
            n++;
        end
        chk_eq(name, (pushed_total >= push_goal && popped_total >= pop_goal), 1);
    endtask

    // Asserts both resets together, checks the cleared state straight away,
    // then releases the resets between clock edges.
    task automatic do_reset();
        #3;
        arstFast = 1'b1; arstSlow = 1'b1;
        push = 1'b0; pop = 1'b0;
        force_aa = 1'b0; allow_udf = 1'b0;
        push_target = 0; pop_target = 0;
        #1;
        chk_eq("rst_empty", empty, 1);
        chk_eq("rst_full", full, 0);
        chk_eq("rst_wr_level", wrLevel, 0);
        chk_eq("rst_rd_level", rdLevel, 0);
        chk_eq("rst_rd_valid", rdValid, 0);
        chk_eq("rst_rd_data", rdData, 0);
        chk_eq("rst_ovf", ovf, 0);
        chk_eq("rst_udf", udf, 0);
        model_q.delete();
        pushed_total = 0; popped_total = 0;
        s_h0 = 0; s_h1 = 0; s_h2 = 0; f_h0 = 0; f_h1 = 0; f_h2 = 0;
        exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        #200;
        arstFast = 1'b0; arstSlow = 1'b0;
        slow_q = ckSlow; fast_q = ckFast;
    endtask

    // Aborts the run if it somehow stalls.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        push = 1'b0; pop = 1'b0; wrData = '0;
        word_random = 1'b0; word_base = 0; wr_prob = 100; rd_prob = 100;
        got_n = 0; aa_seen = 0;
        do_reset();

        // Pop while empty right after reset, then a single word round trip.
        allow_udf = 1'b1;
        run(20);
        allow_udf = 1'b0;
        run(4);
        chk_eq("udf_after_empty_pop", udf, 1);
        chk_eq("no_valid_on_empty_pop", rdValid, 0);
        word_base = 8'h5C; got_n = 0;
        push_target = 1; pop_target = 1;
        run_until(1, 1, 2000, "single_word_done");
        run(20);
        chk_eq("single_word", got_data[0], 8'h5C);

        // Fill with 0x00..0x0F, overflow with 0xAA, then drain.
        do_reset();
        word_base = 0; got_n = 0; aa_seen = 0;
        push_target = 16;
        run_until(16, 0, 3000, "fill_done");
        run(60);
        chk_eq("full_at_16", full, 1);
        chk_eq("wr_level_16", wrLevel, 16);
        chk_eq("rd_level_16", rdLevel, 16);
        force_aa = 1'b1;
        run(40);
        force_aa = 1'b0;
        run(20);
        chk_eq("ovf_after_drop", ovf, 1);
        pop_target = 16;
        run_until(16, 16, 3000, "drain_done");
        run(60);
        for (int i = 0; i < 16; i++) chk_eq($sformatf("seq_word_%0d", i), got_data[i], i);
        chk_eq("no_aa_popped", aa_seen, 0);
        chk_eq("empty_after_drain", empty, 1);
        chk_eq("full_after_drain", full, 0);
        chk_eq("rd_level_after_drain", rdLevel, 0);

        // Random stream of 1000 words with varying push/pop duty.
        do_reset();
        word_random = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wr_prob = $urandom_range(100, 30);
            rd_prob = $urandom_range(100, 25);
            push_target += 100;
            pop_target  += 100;
            run_until(push_target, pop_target, 40000, $sformatf("stream_chunk_%0d", c));
        end
        run(60);
        chk_eq("stream_ovf", ovf, 0);
        chk_eq("stream_udf", udf, 0);
        chk_eq("stream_empty", empty, 1);

        // Hold 7 words, reset both domains, and check the next word is first out.
        wr_prob = 100; rd_prob = 100;
        push_target = pushed_total + 7;
        run_until(push_target, 0, 3000, "hold7_done");
        run(60);
        chk_eq("hold7_wr_level", wrLevel, 7);
        chk_eq("hold7_rd_level", rdLevel, 7);
        do_reset();
        word_random = 1'b0; word_base = 8'h3E; got_n = 0;
        push_target = 1; pop_target = 1;
        run_until(1, 1, 2000, "post_reset_done");
        run(20);
        chk_eq("post_reset_first_word", got_data[0], 8'h3E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ck_slow2fast_fifo.md
CK_SLOW2FAST_FIFO -- requirements
Module: ck_slow2fast_fifo

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, 8, data word width.
REQ-002 Parameter ADDR_W SHALL be: ADDR_W, 4, address width; depth is 2^ADDR_W (16) entries.
REQ-003 Port: ckSlow  in  1  write-domain clock.
REQ-004 Port: ckFast  in  1  read-domain clock.
REQ-005 Port: arstFast  in  1  reset arstFast, asynchronous, active-high; resets the read (ckFast) domain.
REQ-006 Port: arstSlow  in  1  asynchronous, active-high; resets the write (ckSlow) domain.
REQ-007 Port: wrData  in  DATA_W  write data, ckSlow domain.
REQ-008 Port: push  in  1  write request, ckSlow domain.
REQ-009 Port: full  out  1  FIFO full, ckSlow domain.
REQ-010 Port: wrLevel  out  ADDR_W+1  conservative occupancy seen by the writer.
REQ-011 Port: ovf  out  1  sticky overflow flag, ckSlow domain.
REQ-012 Port: pop  in  1  read request, ckFast domain.
REQ-013 Port: rdData  out  DATA_W  registered read data, ckFast domain.
REQ-014 Port: rdValid  out  1  rdData carries a newly popped word, ckFast domain.
REQ-015 Port: empty  out  1  FIFO empty, ckFast domain.
REQ-016 Port: rdLevel  out  ADDR_W+1  conservative occupancy seen by the reader.
REQ-017 Port: udf  out  1  sticky underflow flag, ckFast domain.

Function
REQ-018 Write and read pointers SHALL be ADDR_W+1-bit binary counters, each with a registered Gray copy g = b ^ (b >> 1); both wrap modulo 2^(ADDR_W+1).
REQ-019 A push with push=1 and full=0 at a ckSlow edge SHALL write wrData to mem[wbin[ADDR_W-1:0]] and increment wbin by 1.
REQ-020 A push with full=1 SHALL be dropped, leave pointers and memory unchanged, and set ovf=1.
REQ-021 The write Gray pointer SHALL cross into ckFast through a 2-flop synchronizer, reset by arstFast; the read Gray pointer SHALL cross into ckSlow through a 2-flop synchronizer, reset by arstSlow.
REQ-022 Only Gray-coded pointers SHALL cross domains; no binary or multi-bit data path other than memory contents SHALL cross.
REQ-023 empty SHALL be a register set when the next read Gray pointer equals the synchronized write Gray pointer.
REQ-024 full SHALL be a register set when the next write Gray pointer equals the synchronized read Gray pointer with its two MSBs inverted.
REQ-025 A pop with pop=1 and empty=0 at a ckFast edge SHALL load rdData from mem[rbin[ADDR_W-1:0]], increment rbin, and drive rdValid=1 for exactly the following cycle.
REQ-026 In the 1-cycle pop latency, rdData SHALL update at the edge that samples pop and hold its value otherwise.
REQ-027 A pop with empty=1 SHALL leave rbin unchanged, keep rdValid=0, and set udf=1.
REQ-028 wrLevel SHALL equal wbin minus the binary-converted synchronized read pointer, modulo 2^(ADDR_W+1); rdLevel SHALL be the mirror computation in ckFast. Both are registered.
REQ-029 After a push at a ckSlow edge, empty SHALL deassert no later than the 3rd subsequent ckFast edge.
REQ-030 After a pop, full SHALL deassert no later than the 3rd subsequent ckSlow edge.
REQ-031 Concurrent push and pop in the two domains SHALL be legal at any occupancy, and no word SHALL be lost, duplicated, or reordered.
REQ-032 ovf and udf SHALL remain set until the reset of their own domain.

Reset
REQ-033 arstFast=1 SHALL immediately clear rbin, the read Gray pointer, the ckFast synchronizer, rdData (0), rdValid (0), rdLevel (0), and udf (0), and SHALL set empty=1.
REQ-034 arstSlow=1 SHALL immediately clear wbin, the write Gray pointer, the ckSlow synchronizer, full (0), wrLevel (0), and ovf (0).
REQ-035 A FIFO reset SHALL consist of arstFast and arstSlow asserted together; asserting one alone mid-operation is unsupported, and the system SHALL then reassert both.
REQ-036 Memory contents SHALL NOT be reset.

Verification
REQ-037 ckSlow 10 MHz, ckFast 37 MHz: push 0x00..0x0F, then pop 16 times -> rdData sequence 0x00..0x0F with rdValid pulses; empty=1 at the end.
REQ-038 Push 16 words -> full=1 and wrLevel=16; a 17th push of 0xAA -> ovf=1, and the popped data contains no 0xAA.
REQ-039 Pop while empty=1 after reset -> udf=1, rdValid stays 0, and a subsequent single push/pop returns the pushed word.
REQ-040 Stream 1000 random words with random push/pop gaps (wrap past 32 pointer values several times) -> the scoreboard matches exactly, with no ovf or udf.
REQ-041 Assert arstFast and arstSlow together with 7 words held -> empty=1, full=0, both levels 0, and the next pushed word is the first one popped.
